axis_width_adapter: RTL and testbench

- Single-clock AXI4-Stream bus width converter; changes bus width by whole byte lanes and keeps frame boundaries and sideband data intact.
- Three modes, selected at elaboration:
  - upsize: input narrower, lanes packed into a wider word;
  - downsize: input wider, word split into narrower beats;
  - passthrough: equal lane counts.
- Placed in front of or behind async FIFOs so the FIFO always runs at the wider width.

---
 rtl/axis_width_adapter.sv | 181 ++++++++++++++++++
 tb/tb_axis_width_adapter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_width_adapter.sv
// axis_width_adapter: AXI4-Stream converter that packs or splits whole byte lanes,
// keeping tlast and tid/tdest/tuser aligned with the data they describe.
module axis_width_adapter #(
    parameter int S_DATA_WIDTH  = 8,
    parameter int S_KEEP_ENABLE = (S_DATA_WIDTH > 8),
    parameter int S_KEEP_WIDTH  = ((S_DATA_WIDTH + 7) / 8),
    parameter int M_DATA_WIDTH  = 8,
    parameter int M_KEEP_ENABLE = (M_DATA_WIDTH > 8),
    parameter int M_KEEP_WIDTH  = ((M_DATA_WIDTH + 7) / 8),
    parameter int ID_ENABLE     = 0,
    parameter int ID_WIDTH      = 8,
    parameter int DEST_ENABLE   = 0,
    parameter int DEST_WIDTH    = 8,
    parameter int USER_ENABLE   = 1,
    parameter int USER_WIDTH    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [S_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    input  logic [ID_WIDTH-1:0]     s_axis_tid,
    input  logic [DEST_WIDTH-1:0]   s_axis_tdest,
    input  logic [USER_WIDTH-1:0]   s_axis_tuser,
    output logic [M_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [M_KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic [ID_WIDTH-1:0]     m_axis_tid,
    output logic [DEST_WIDTH-1:0]   m_axis_tdest,
    output logic [USER_WIDTH-1:0]   m_axis_tuser
);
    localparam int S_LANES   = S_KEEP_ENABLE != 0 ? S_KEEP_WIDTH : 1;
    localparam int M_LANES   = M_KEEP_ENABLE != 0 ? M_KEEP_WIDTH : 1;
    localparam int S_LANE_W  = S_DATA_WIDTH / S_LANES;
    localparam int M_LANE_W  = M_DATA_WIDTH / M_LANES;
    localparam int WIDE      = M_LANES > S_LANES ? M_LANES : S_LANES;
    localparam int NARROW    = M_LANES > S_LANES ? S_LANES : M_LANES;
    localparam int SEG_COUNT = WIDE / NARROW;
    localparam int SEG_W     = SEG_COUNT > 1 ? $clog2(SEG_COUNT) : 1;
    localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(SEG_COUNT - 1);

    if (S_DATA_WIDTH % S_LANES != 0 || M_DATA_WIDTH % M_LANES != 0) begin : g_err_lane
        $fatal(1, "axis_width_adapter: data width not evenly divisible into lanes");
    end
    if (S_LANE_W != M_LANE_W) begin : g_err_size
        $fatal(1, "axis_width_adapter: input and output lane sizes differ");
    end
    if (WIDE % NARROW != 0) begin : g_err_seg
        $fatal(1, "axis_width_adapter: wide lane count is not a multiple of narrow lane count");
    end

    logic [S_LANES-1:0]      w_s_keep;
    logic                    w_s_ready;
    logic [M_DATA_WIDTH-1:0] w_m_data;
    logic [M_LANES-1:0]      w_m_keep;
    logic                    w_m_valid;
    logic                    w_m_last;
    logic [ID_WIDTH-1:0]     w_m_id;
    logic [DEST_WIDTH-1:0]   w_m_dest;
    logic [USER_WIDTH-1:0]   w_m_user;
    logic                    w_unused;

    if (S_KEEP_ENABLE != 0) begin : g_skeep
        assign w_s_keep = s_axis_tkeep;
    end else begin : g_sones
        assign w_s_keep = '1;
    end

    if (M_KEEP_ENABLE != 0) begin : g_mkeep
        assign m_axis_tkeep = w_m_keep;
    end else begin : g_mones
        assign m_axis_tkeep = '1;
    end

    if (M_LANES == S_LANES) begin : g_pass
        assign w_s_ready = m_axis_tready;
        assign w_m_data  = s_axis_tdata;
        assign w_m_keep  = w_s_keep;
        assign w_m_valid = s_axis_tvalid;
        assign w_m_last  = s_axis_tlast;
        assign w_m_id    = s_axis_tid;
        assign w_m_dest  = s_axis_tdest;
        assign w_m_user  = s_axis_tuser;
    end else if (M_LANES > S_LANES) begin : g_up
        logic [M_DATA_WIDTH-1:0] r_data;
        logic [M_LANES-1:0]      r_keep;
        logic                    r_valid;
        logic                    r_last;
        logic [ID_WIDTH-1:0]     r_id;
        logic [DEST_WIDTH-1:0]   r_dest;
        logic [USER_WIDTH-1:0]   r_user;
        logic [SEG_W-1:0]        r_seg;
        assign w_s_ready = !r_valid || m_axis_tready;
        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
                r_seg   <= '0;
            end else begin
                if (m_axis_tready) r_valid <= 1'b0;
                if (s_axis_tvalid && w_s_ready) begin
                    // later slice write overrides the clear, leaving only higher lanes zeroed
                    if (r_seg == '0) r_keep <= '0;
                    r_keep[r_seg*S_LANES +: S_LANES]           <= w_s_keep;
                    r_data[r_seg*S_DATA_WIDTH +: S_DATA_WIDTH] <= s_axis_tdata;
                    r_id   <= s_axis_tid;
                    r_dest <= s_axis_tdest;
                    r_user <= s_axis_tuser;
                    if (r_seg == SEG_LAST || s_axis_tlast) begin
                        r_valid <= 1'b1;
                        r_last  <= s_axis_tlast;
                        r_seg   <= '0;
                    end else begin
                        r_seg <= r_seg + 1'b1;
                    end
                end
            end
        end
        assign w_m_data  = r_data;
        assign w_m_keep  = r_keep;
        assign w_m_valid = r_valid;
        assign w_m_last  = r_last;
        assign w_m_id    = r_id;
        assign w_m_dest  = r_dest;
        assign w_m_user  = r_user;
    end else begin : g_down
        logic [S_DATA_WIDTH-1:0] r_data;
        logic [S_LANES-1:0]      r_keep;
        logic                    r_full;
        logic                    r_last;
        logic [ID_WIDTH-1:0]     r_id;
        logic [DEST_WIDTH-1:0]   r_dest;
        logic [USER_WIDTH-1:0]   r_user;
        logic [SEG_W-1:0]        r_seg;
        logic                    w_final;
        logic                    w_done;
        // a segment is final once nothing above it carries valid lanes
        assign w_final   = r_seg == SEG_LAST || (r_keep >> ((int'(r_seg) + 1) * M_LANES)) == '0;
        assign w_done    = r_full && m_axis_tready && w_final;
        assign w_s_ready = !r_full || w_done;
        always_ff @(posedge clk) begin
            if (rst) begin
                r_full <= 1'b0;
                r_last <= 1'b0;
                r_seg  <= '0;
            end else begin
                if (r_full && m_axis_tready) r_seg <= w_final ? '0 : r_seg + 1'b1;
                if (w_done) r_full <= 1'b0;
                if (s_axis_tvalid && w_s_ready) begin
                    r_full <= 1'b1;
                    r_data <= s_axis_tdata;
                    r_keep <= w_s_keep;
                    r_last <= s_axis_tlast;
                    r_id   <= s_axis_tid;
                    r_dest <= s_axis_tdest;
                    r_user <= s_axis_tuser;
                end
            end
        end
        assign w_m_data  = r_data[r_seg*M_DATA_WIDTH +: M_DATA_WIDTH];
        assign w_m_keep  = r_keep[r_seg*M_LANES +: M_LANES];
        assign w_m_valid = r_full;
        assign w_m_last  = r_full && r_last && w_final;
        assign w_m_id    = r_id;
        assign w_m_dest  = r_dest;
        assign w_m_user  = r_user;
    end

    assign s_axis_tready = w_s_ready;
    assign m_axis_tdata  = w_m_data;
    assign m_axis_tvalid = w_m_valid;
    assign m_axis_tlast  = w_m_last;
    assign m_axis_tid    = ID_ENABLE != 0 ? w_m_id : '0;
    assign m_axis_tdest  = DEST_ENABLE != 0 ? w_m_dest : '0;
    assign m_axis_tuser  = USER_ENABLE != 0 ? w_m_user : '0;
    assign w_unused      = ^{clk, rst, s_axis_tkeep, w_m_keep};
endmodule

// File: tb/tb_axis_width_adapter.sv
// tb_axis_width_adapter: directed checks of upsize 8->32, downsize 32->8 and 64->16, passthrough 32->32.
module tb_axis_width_adapter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    logic [7:0]  up_s_data = '0;
    logic        up_s_keep = 1'b1;
    logic        up_s_valid = 1'b0, up_s_ready, up_s_last = 1'b0;
    logic [7:0]  up_s_id = 8'h77, up_s_dest = 8'h00;
    logic        up_s_user = 1'b0;
    logic [31:0] up_m_data;
    logic [3:0]  up_m_keep;
    logic        up_m_valid, up_m_ready = 1'b1, up_m_last;
    logic [7:0]  up_m_id, up_m_dest;
    logic        up_m_user;

    logic [31:0] dn_s_data = '0;
    logic [3:0]  dn_s_keep = '0;
    logic        dn_s_valid = 1'b0, dn_s_ready, dn_s_last = 1'b0;
    logic [7:0]  dn_s_id = '0, dn_s_dest = '0;
    logic        dn_s_user = 1'b0;
    logic [7:0]  dn_m_data;
    logic        dn_m_keep;
    logic        dn_m_valid, dn_m_ready = 1'b1, dn_m_last;
    logic [7:0]  dn_m_id, dn_m_dest;
    logic        dn_m_user;

    logic [63:0] d6_s_data = '0;
    logic [7:0]  d6_s_keep = 8'hFF;
    logic        d6_s_valid = 1'b0, d6_s_ready, d6_s_last = 1'b0;
    logic [7:0]  d6_s_id = '0, d6_s_dest = '0;
    logic        d6_s_user = 1'b0;
    logic [15:0] d6_m_data;
    logic [1:0]  d6_m_keep;
    logic        d6_m_valid, d6_m_ready = 1'b1, d6_m_last;
    logic [7:0]  d6_m_id, d6_m_dest;
    logic        d6_m_user;

    logic [31:0] pt_s_data = '0;
    logic [3:0]  pt_s_keep = '0;
    logic        pt_s_valid = 1'b0, pt_s_ready, pt_s_last = 1'b0;
    logic [7:0]  pt_s_id = '0, pt_s_dest = '0;
    logic        pt_s_user = 1'b0;
    logic [31:0] pt_m_data;
    logic [3:0]  pt_m_keep;
    logic        pt_m_valid, pt_m_ready = 1'b0, pt_m_last;
    logic [7:0]  pt_m_id, pt_m_dest;
    logic        pt_m_user;

    axis_width_adapter #(.S_DATA_WIDTH(8), .M_DATA_WIDTH(32)) u_up (
        .clk(clk), .rst(rst),
        .s_axis_tdata(up_s_data), .s_axis_tkeep(up_s_keep), .s_axis_tvalid(up_s_valid),
        .s_axis_tready(up_s_ready), .s_axis_tlast(up_s_last), .s_axis_tid(up_s_id),
        .s_axis_tdest(up_s_dest), .s_axis_tuser(up_s_user),
        .m_axis_tdata(up_m_data), .m_axis_tkeep(up_m_keep), .m_axis_tvalid(up_m_valid),
        .m_axis_tready(up_m_ready), .m_axis_tlast(up_m_last), .m_axis_tid(up_m_id),
        .m_axis_tdest(up_m_dest), .m_axis_tuser(up_m_user));

    axis_width_adapter #(.S_DATA_WIDTH(32), .M_DATA_WIDTH(8)) u_dn (
        .clk(clk), .rst(rst),
        .s_axis_tdata(dn_s_data), .s_axis_tkeep(dn_s_keep), .s_axis_tvalid(dn_s_valid),
        .s_axis_tready(dn_s_ready), .s_axis_tlast(dn_s_last), .s_axis_tid(dn_s_id),
        .s_axis_tdest(dn_s_dest), .s_axis_tuser(dn_s_user),
        .m_axis_tdata(dn_m_data), .m_axis_tkeep(dn_m_keep), .m_axis_tvalid(dn_m_valid),
        .m_axis_tready(dn_m_ready), .m_axis_tlast(dn_m_last), .m_axis_tid(dn_m_id),
        .m_axis_tdest(dn_m_dest), .m_axis_tuser(dn_m_user));

    axis_width_adapter #(.S_DATA_WIDTH(64), .M_DATA_WIDTH(16), .ID_ENABLE(1)) u_d6 (
        .clk(clk), .rst(rst),
        .s_axis_tdata(d6_s_data), .s_axis_tkeep(d6_s_keep), .s_axis_tvalid(d6_s_valid),
        .s_axis_tready(d6_s_ready), .s_axis_tlast(d6_s_last), .s_axis_tid(d6_s_id),
        .s_axis_tdest(d6_s_dest), .s_axis_tuser(d6_s_user),
        .m_axis_tdata(d6_m_data), .m_axis_tkeep(d6_m_keep), .m_axis_tvalid(d6_m_valid),
        .m_axis_tready(d6_m_ready), .m_axis_tlast(d6_m_last), .m_axis_tid(d6_m_id),
        .m_axis_tdest(d6_m_dest), .m_axis_tuser(d6_m_user));

    axis_width_adapter #(.S_DATA_WIDTH(32), .M_DATA_WIDTH(32)) u_pt (
        .clk(clk), .rst(rst),
        .s_axis_tdata(pt_s_data), .s_axis_tkeep(pt_s_keep), .s_axis_tvalid(pt_s_valid),
        .s_axis_tready(pt_s_ready), .s_axis_tlast(pt_s_last), .s_axis_tid(pt_s_id),
        .s_axis_tdest(pt_s_dest), .s_axis_tuser(pt_s_user),
        .m_axis_tdata(pt_m_data), .m_axis_tkeep(pt_m_keep), .m_axis_tvalid(pt_m_valid),
        .m_axis_tready(pt_m_ready), .m_axis_tlast(pt_m_last), .m_axis_tid(pt_m_id),
        .m_axis_tdest(pt_m_dest), .m_axis_tuser(pt_m_user));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic up_beat(input logic [7:0] d, input logic l);
        up_s_data  = d;
        up_s_last  = l;
        up_s_valid = 1'b1;
        tick();
    endtask

    task automatic d6_load(input int k);
        for (int j = 0; j < 4; j++) d6_s_data[j*16 +: 16] = 16'(16'hA000 + k * 16 + j);
        d6_s_id    = k < 2 ? 8'd5 : 8'd3;
        d6_s_user  = k < 2;
        d6_s_last  = k == 3;
        d6_s_valid = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] bytes [0:3];
        int nb, first, lastc;
        logic acc;
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
        tick();
        tick();
        chk("rst_up_valid", up_m_valid, 1'b0);
        chk("rst_up_ready", up_s_ready, 1'b1);
        chk("rst_dn_valid", dn_m_valid, 1'b0);
        chk("rst_dn_last", dn_m_last, 1'b0);
        chk("rst_d6_valid", d6_m_valid, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            up_s_user = i == 3;
            up_beat(bytes[i], i == 3);
            if (i < 3) chk("up1_partial_valid", up_m_valid, 1'b0);
        end
        up_s_valid = 1'b0;
        chk("up1_valid", up_m_valid, 1'b1);
        chk("up1_data", up_m_data, 32'h44332211);
        chk("up1_keep", up_m_keep, 4'hF);
        chk("up1_last", up_m_last, 1'b1);
        chk("up1_user", up_m_user, 1'b1);
        chk("up1_tid_off", up_m_id, 8'h00);
        tick();
        chk("up1_drain", up_m_valid, 1'b0);

        up_s_user = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            up_beat(8'(i), i == 6);
            if (i == 4) begin
                chk("up2_w0_valid", up_m_valid, 1'b1);
                chk("up2_w0_data", up_m_data, 32'h04030201);
                chk("up2_w0_keep", up_m_keep, 4'hF);
                chk("up2_w0_last", up_m_last, 1'b0);
            end
            if (i == 5) chk("up2_mid_valid", up_m_valid, 1'b0);
        end
        up_s_valid = 1'b0;
        chk("up2_w1_valid", up_m_valid, 1'b1);
        chk("up2_w1_data", up_m_data[15:0], 16'h0605);
        chk("up2_w1_keep", up_m_keep, 4'h3);
        chk("up2_w1_last", up_m_last, 1'b1);
        tick();

        up_m_ready = 1'b0;
        for (int i = 1; i <= 4; i++) up_beat(8'(8'hA0 + i), 1'b0);
        chk("bp_valid", up_m_valid, 1'b1);
        chk("bp_data", up_m_data, 32'hA4A3A2A1);
        up_s_data  = 8'hB1;
        up_s_valid = 1'b1;
        #1;
        chk("bp_sready_low", up_s_ready, 1'b0);
        tick();
        tick();
        chk("bp_hold_valid", up_m_valid, 1'b1);
        chk("bp_hold_data", up_m_data, 32'hA4A3A2A1);
        chk("bp_hold_sready", up_s_ready, 1'b0);
        up_m_ready = 1'b1;
        #1;
        chk("bp_sready_resume", up_s_ready, 1'b1);
        tick();
        chk("bp_consumed", up_m_valid, 1'b0);
        for (int i = 2; i <= 4; i++) up_beat(8'(8'hB0 + i), i == 4);
        up_s_valid = 1'b0;
        chk("bp_w1_valid", up_m_valid, 1'b1);
        chk("bp_w1_data", up_m_data, 32'hB4B3B2B1);
        chk("bp_w1_last", up_m_last, 1'b1);
        tick();
        chk("bp_no_dup", up_m_valid, 1'b0);

        up_m_ready = 1'b0;
        for (int i = 1; i <= 4; i++) up_beat(8'(8'hC0 + i), 1'b0);
        up_s_valid = 1'b0;
        chk("rst_pend_valid", up_m_valid, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_valid", up_m_valid, 1'b0);
        chk("rst_mid_last", up_m_last, 1'b0);
        up_m_ready = 1'b1;
        up_beat(8'hE1, 1'b0);
        up_beat(8'hE2, 1'b0);
        up_s_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) up_beat(8'(8'hD0 + i), i == 4);
        up_s_valid = 1'b0;
        chk("rst_seg0_valid", up_m_valid, 1'b1);
        chk("rst_seg0_data", up_m_data, 32'hD4D3D2D1);
        chk("rst_seg0_keep", up_m_keep, 4'hF);

        dn_s_data  = 32'hDDCCBBAA;
        dn_s_keep  = 4'h7;
        dn_s_last  = 1'b1;
        dn_s_valid = 1'b1;
        #1;
        chk("dn_sready_empty", dn_s_ready, 1'b1);
        tick();
        dn_s_valid = 1'b0;
        chk("dn_b0_valid", dn_m_valid, 1'b1);
        chk("dn_b0_data", dn_m_data, 8'hAA);
        chk("dn_b0_last", dn_m_last, 1'b0);
        chk("dn_b0_sready", dn_s_ready, 1'b0);
        tick();
        chk("dn_b1_data", dn_m_data, 8'hBB);
        chk("dn_b1_last", dn_m_last, 1'b0);
        chk("dn_b1_sready", dn_s_ready, 1'b0);
        tick();
        chk("dn_b2_data", dn_m_data, 8'hCC);
        chk("dn_b2_last", dn_m_last, 1'b1);
        chk("dn_b2_sready", dn_s_ready, 1'b1);
        tick();
        chk("dn_drained", dn_m_valid, 1'b0);
        dn_s_data  = 32'h12345678;
        dn_s_keep  = 4'h0;
        dn_s_valid = 1'b1;
        tick();
        dn_s_valid = 1'b0;
        chk("dn_k0_valid", dn_m_valid, 1'b1);
        chk("dn_k0_data", dn_m_data, 8'h78);
        chk("dn_k0_last", dn_m_last, 1'b1);
        tick();
        chk("dn_k0_single", dn_m_valid, 1'b0);

        nb = 0;
        first = -1;
        lastc = 0;
        d6_load(0);
        begin
            int k;
            k = 0;
            for (int c = 0; c < 40; c++) begin
                #1;
                acc = d6_s_valid && d6_s_ready;
                if (d6_m_valid) begin
                    chk("d6_data", d6_m_data, 16'(16'hA000 + (nb / 4) * 16 + nb % 4));
                    chk("d6_keep", d6_m_keep, 2'b11);
                    chk("d6_tid", d6_m_id, nb / 4 < 2 ? 8'd5 : 8'd3);
                    chk("d6_user", d6_m_user, nb / 4 < 2);
                    chk("d6_last", d6_m_last, nb == 15);
                    if (first < 0) first = c;
                    lastc = c;
                    nb++;
                end
                @(posedge clk);
                #1;
                if (acc) begin
                    k++;
                    if (k < 4) d6_load(k);
                    else d6_s_valid = 1'b0;
                end
            end
        end
        chk("d6_beats", 64'(nb), 64'd16);
        chk("d6_gapless", 64'(lastc - first + 1), 64'd16);

        pt_s_data  = 32'hCAFEBABE;
        pt_s_keep  = 4'h5;
        pt_s_last  = 1'b1;
        pt_s_user  = 1'b1;
        pt_s_id    = 8'h09;
        pt_s_valid = 1'b1;
        #1;
        chk("pt_sready_low", pt_s_ready, 1'b0);
        chk("pt_valid", pt_m_valid, 1'b1);
        chk("pt_data", pt_m_data, 32'hCAFEBABE);
        chk("pt_keep", pt_m_keep, 4'h5);
        chk("pt_last", pt_m_last, 1'b1);
        chk("pt_user", pt_m_user, 1'b1);
        chk("pt_tid_off", pt_m_id, 8'h00);
        pt_m_ready = 1'b1;
        #1;
        chk("pt_sready_high", pt_s_ready, 1'b1);
        pt_s_data  = 32'h01020304;
        pt_s_keep  = 4'hF;
        pt_s_last  = 1'b0;
        pt_s_user  = 1'b0;
        pt_s_valid = 1'b0;
        #1;
        chk("pt_data2", pt_m_data, 32'h01020304);
        chk("pt_keep2", pt_m_keep, 4'hF);
        chk("pt_valid2", pt_m_valid, 1'b0);
        chk("pt_last2", pt_m_last, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
